// File: rtl/exu_mem_arb_pkg.sv
// Shared types for the EXU data-memory arbiter.
// Holds the FSM encoding and the latched request bundle.
package exu_mem_arb_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    TOUT
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  sel;
  } req_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exu_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above
// i_last, wrapping. Usable by any shared resource.
module rr_pick
  import exu_mem_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  int w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    for (int k = 1; k <= N; k++) begin
      w_j = (int'(i_last) + k) % N;
      if (!o_valid && i_req[w_j]) begin
        o_valid     = 1'b1;
        o_gnt[w_j]  = 1'b1;
        o_idx       = W'(w_j);
      end
    end
  end

endmodule

// File: rtl/exu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port, one txn in flight.
// Optional response timeout: define EXU_MEM_ARB_TIMEOUT_EN.
module exu_mem_arbiter
  import exu_mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_req_valid_i,
  output logic [NUM_MASTERS-1:0]    m_req_ready_o,
  input  logic [NUM_MASTERS*32-1:0] m_addr_i,
  input  logic [NUM_MASTERS*32-1:0] m_wdata_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
  output logic [NUM_MASTERS-1:0]    m_rsp_valid_o,
  input  logic [NUM_MASTERS-1:0]    m_rsp_ready_i,
  output logic [31:0]               m_rdata_o,
  output logic                      m_rsp_err_o,
  output logic                      s_req_valid_o,
  input  logic                      s_req_ready_i,
  output logic [31:0]               s_addr_o,
  output logic [31:0]               s_wdata_o,
  output logic                      s_we_o,
  output logic [3:0]                s_sel_o,
  input  logic                      s_rsp_valid_i,
  output logic                      s_rsp_ready_o,
  input  logic [31:0]               s_rdata_i
);

  localparam int IW = idx_w(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS ||
      TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("exu_mem_arbiter: parameter out of range");
  end

  state_e                 r_state;
  state_e                 w_next;
  logic [IW-1:0]          r_owner;
  logic [IW-1:0]          r_last;
  req_t                   r_req;

  logic [NUM_MASTERS-1:0] w_gnt;
  logic [IW-1:0]          w_idx;
  logic                   w_any;
  req_t                   w_win;
  logic [NUM_MASTERS-1:0] w_own_sel;
  logic                   w_own_rdy;
  logic                   w_rsp_hs;
  logic                   w_done;

  rr_pick #(
    .N (NUM_MASTERS),
    .W (IW)
  ) u_pick (
    .i_req   (m_req_valid_i),
    .i_last  (r_last),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_idx == IW'(i)) begin
        w_win.addr  = m_addr_i[i*32 +: 32];
        w_win.wdata = m_wdata_i[i*32 +: 32];
        w_win.we    = m_we_i[i];
        w_win.sel   = m_sel_i[i*4 +: 4];
      end
    end
  end

  assign w_own_sel = NUM_MASTERS'(1) << r_owner;
  assign w_own_rdy = |(m_rsp_ready_i & w_own_sel);
  assign w_rsp_hs  = (r_state == RSP) &&
                     s_rsp_valid_i && w_own_rdy;

`ifdef EXU_MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          w_tout_hit;

  assign w_tout_hit = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_done     = w_rsp_hs ||
                      ((r_state == TOUT) && w_own_rdy);

  // Counts RSP cycles waiting on the bus; idle elsewhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state != RSP) begin
      r_cnt <= '0;
    end else if (!w_rsp_hs) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_done = w_rsp_hs;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
      r_req   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_owner <= w_idx;
        r_req   <= w_win;
      end
      if (w_done) begin
        r_last <= r_owner;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next = s_req_ready_i ? RSP : REQ;
        end
      end
      REQ: begin
        if (s_req_ready_i) begin
          w_next = RSP;
        end
      end
      RSP: begin
        if (w_rsp_hs) begin
          w_next = IDLE;
`ifdef EXU_MEM_ARB_TIMEOUT_EN
        end else if (w_tout_hit) begin
          w_next = TOUT;
`endif
        end
      end
`ifdef EXU_MEM_ARB_TIMEOUT_EN
      TOUT: begin
        if (w_own_rdy) begin
          w_next = IDLE;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // Outputs forced low while reset is held, even mid-transaction
  always_comb begin
    m_req_ready_o = '0;
    m_rsp_valid_o = '0;
    m_rdata_o     = '0;
    m_rsp_err_o   = 1'b0;
    s_req_valid_o = 1'b0;
    s_addr_o      = '0;
    s_wdata_o     = '0;
    s_we_o        = 1'b0;
    s_sel_o       = '0;
    s_rsp_ready_o = 1'b0;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            s_req_valid_o = 1'b1;
            s_addr_o      = w_win.addr;
            s_wdata_o     = w_win.wdata;
            s_we_o        = w_win.we;
            s_sel_o       = w_win.sel;
            m_req_ready_o = w_gnt &
                            {NUM_MASTERS{s_req_ready_i}};
          end
        end
        REQ: begin
          s_req_valid_o = 1'b1;
          s_addr_o      = r_req.addr;
          s_wdata_o     = r_req.wdata;
          s_we_o        = r_req.we;
          s_sel_o       = r_req.sel;
        end
        RSP: begin
          m_rsp_valid_o = w_own_sel &
                          {NUM_MASTERS{s_rsp_valid_i}};
          s_rsp_ready_o = w_own_rdy;
          m_rdata_o     = s_rdata_i;
        end
`ifdef EXU_MEM_ARB_TIMEOUT_EN
        TOUT: begin
          m_rsp_valid_o = w_own_sel;
          m_rsp_err_o   = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
